// File: rtl/and_gate_pkg.sv
// ---------------------------------------------------------------------------
// and_gate_pkg
// Shared constants and types for the and_gate cell and its counter.
//   AND_WIDTH_DEF : default operand width of the AND cell
//   AND_CNT_W_DEF : default width of the all-ones cycle counter
//   and_cnt_t     : counter word at the default counter width
// ---------------------------------------------------------------------------
package and_gate_pkg;

    localparam int AND_WIDTH_DEF = 1;
    localparam int AND_CNT_W_DEF = 16;

    typedef logic [AND_CNT_W_DEF-1:0] and_cnt_t;

endpackage : and_gate_pkg

// File: rtl/and_sat_counter.sv
// ---------------------------------------------------------------------------
// and_sat_counter
// Saturating up-counter with synchronous active-low reset and synchronous
// clear. Clear wins over increment; the count sticks at all-ones.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active-low
//   clr   : synchronous clear to zero
//   inc   : count-enable for this cycle
//   count : current count (CNT_W bits)
// ---------------------------------------------------------------------------
module and_sat_counter
    import and_gate_pkg::*;
#(
    parameter int CNT_W = AND_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule : and_sat_counter

// File: rtl/and_gate.sv
// ---------------------------------------------------------------------------
// and_gate
// Bitwise two-input AND with a clocked observation stage.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous reset, active-low (observation state only)
//   a, b     : operands, WIDTH bits
//   clr      : synchronous clear of hi_count
//   y        : a & b, purely combinational
//   y_q      : y registered
//   y_rise   : per-bit rising flag, y sampled 1 while y_q was 0
//   hi_count : saturating count of cycles where every bit of y was 1
// ---------------------------------------------------------------------------
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = AND_WIDTH_DEF,
    parameter int CNT_W = AND_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] y_rise,
    output logic [CNT_W-1:0] hi_count
);

    logic all_ones;

    // Combinational stage: no clock or reset involvement, valid during reset.
    assign y        = a & b;
    assign all_ones = &y;

    // Observation stage: y_rise uses the pre-edge y_q, so a steady 1
    // produces a single pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q    <= '0;
            y_rise <= '0;
        end else begin
            y_q    <= y;
            y_rise <= y & ~y_q;
        end
    end

    and_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (all_ones),
        .count (hi_count)
    );

endmodule : and_gate

// File: tb/tb_and_gate.sv
// ---------------------------------------------------------------------------
// tb_and_gate
// Self-checking bench for and_gate: three instances (default sizes, a
// 3-bit saturating counter, and a 4-bit wide gate) share clock, reset and
// clear, and are compared every cycle against a reference model.
// ---------------------------------------------------------------------------
module tb_and_gate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clr;

    // default instance: WIDTH=1, CNT_W=16
    logic        a1, b1, y1, yq1, yr1;
    logic [15:0] c1;
    // saturation instance: WIDTH=1, CNT_W=3
    logic        as, bs, ys, yqs, yrs;
    logic [2:0]  cs;
    // wide instance: WIDTH=4, CNT_W=16
    logic [3:0]  a4, b4, y4, yq4, yr4;
    logic [15:0] c4;

    and_gate u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr(clr),
        .y(y1), .y_q(yq1), .y_rise(yr1), .hi_count(c1)
    );

    and_gate #(.WIDTH(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(as), .b(bs), .clr(clr),
        .y(ys), .y_q(yqs), .y_rise(yrs), .hi_count(cs)
    );

    and_gate #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .clr(clr),
        .y(y4), .y_q(yq4), .y_rise(yr4), .hi_count(c4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic       m1_q, m1_r, ms_q, ms_r;
    logic [3:0] m4_q, m4_r;
    int         m1_c, ms_c, m4_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_cnt(input int cnt, input logic all, input logic clr_i, input int max);
        if (clr_i) return 0;
        if (all && cnt < max) return cnt + 1;
        return cnt;
    endfunction

    task automatic check_all();
        chk("y1",    32'(y1),  32'(a1 & b1));
        chk("yq1",   32'(yq1), 32'(m1_q));
        chk("rise1", 32'(yr1), 32'(m1_r));
        chk("cnt1",  32'(c1),  32'(m1_c));
        chk("ys",    32'(ys),  32'(as & bs));
        chk("yqs",   32'(yqs), 32'(ms_q));
        chk("rises", 32'(yrs), 32'(ms_r));
        chk("cnts",  32'(cs),  32'(ms_c));
        chk("y4",    32'(y4),  32'(a4 & b4));
        chk("yq4",   32'(yq4), 32'(m4_q));
        chk("rise4", 32'(yr4), 32'(m4_r));
        chk("cnt4",  32'(c4),  32'(m4_c));
    endtask

    // Advance one clock: update the model from the inputs present at the
    // edge, then compare just after the edge; return on the falling edge.
    task automatic tick();
        logic       y1e, yse;
        logic [3:0] y4e;
        y1e = a1 & b1;
        yse = as & bs;
        y4e = a4 & b4;
        if (!rst_n) begin
            m1_q = 0; m1_r = 0; m1_c = 0;
            ms_q = 0; ms_r = 0; ms_c = 0;
            m4_q = 0; m4_r = 0; m4_c = 0;
        end else begin
            m1_r = y1e & ~m1_q;  m1_q = y1e;
            m1_c = next_cnt(m1_c, y1e, clr, 65535);
            ms_r = yse & ~ms_q;  ms_q = yse;
            ms_c = next_cnt(ms_c, yse, clr, 7);
            m4_r = y4e & ~m4_q;  m4_q = y4e;
            m4_c = next_cnt(m4_c, (y4e == 4'hF), clr, 65535);
        end
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    int saved;

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        a1 = 0; b1 = 0; as = 0; bs = 0; a4 = 0; b4 = 0;
        m1_q = 0; m1_r = 0; m1_c = 0;
        ms_q = 0; ms_r = 0; ms_c = 0;
        m4_q = 0; m4_r = 0; m4_c = 0;
        @(negedge clk);

        // truth table, combinational only
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #5;
            chk("tt_y", 32'(y1), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);

        // reset held for two edges with all-ones inputs
        a1 = 1; b1 = 1; as = 1; bs = 1; a4 = 4'hF; b4 = 4'hF;
        tick();
        tick();
        chk("rst_y",    32'(y1),  32'd1);
        chk("rst_yq",   32'(yq1), 32'd0);
        chk("rst_rise", 32'(yr1), 32'd0);
        chk("rst_cnt",  32'(c1),  32'd0);

        // release
        rst_n = 1'b1;
        tick();
        chk("rel_yq",   32'(yq1), 32'd1);
        chk("rel_rise", 32'(yr1), 32'd1);
        tick();
        chk("rel_rise2", 32'(yr1), 32'd0);

        // counting: 5 ones then 3 zeros
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        chk("cnt_5", 32'(c1), 32'd5);
        a1 = 0;
        repeat (3) tick();
        chk("cnt_hold", 32'(c1), 32'd5);

        // saturation instance has seen 8 all-ones edges; two more
        repeat (2) tick();
        chk("sat_7", 32'(cs), 32'd7);

        // clear priority over increment
        a1 = 1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();
        chk("pri_4", 32'(c1), 32'd4);
        clr = 1'b1;
        tick();
        chk("pri_clr", 32'(c1), 32'd0);
        clr = 1'b0;
        tick();
        chk("pri_1", 32'(c1), 32'd1);

        // wide gate: partial match does not count
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        chk("w4_y8", 32'(y4), 32'h8);
        saved = m4_c;
        tick();
        chk("w4_nocnt", 32'(c4), 32'(saved));
        a4 = 4'hF; b4 = 4'hF;
        #1;
        chk("w4_yF", 32'(y4), 32'hF);
        tick();
        chk("w4_rise", 32'(yr4), 32'h7);
        chk("w4_cnt", 32'(c4), 32'(saved + 1));

        // randomized traffic
        repeat (400) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            as = ($urandom_range(0, 3) != 0); bs = ($urandom_range(0, 3) != 0);
            a4 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            b4 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            clr   = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_and_gate

// File: doc/and_gate.md
# and_gate

Parameterizable bitwise two-input AND cell with a zero-latency combinational output and a small clocked observation stage. The observation stage provides a registered copy of the output, rising-edge flags, and a saturating count of all-ones cycles. It serves as a basic logic primitive and as a self-checking leaf for gate-level exercises.

## Interface
- `WIDTH`, default 1: bit width of `a`, `b`, `y`, `y_q`, `y_rise`.
- `CNT_W`, default 16: width of `hi_count`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `clr` input 1: synchronous clear of `hi_count`.
- `y` output WIDTH: `a & b`, purely combinational.
- `y_q` output WIDTH: `y` registered.
- `y_rise` output WIDTH: per-bit flag, `y` was 1 this sample and `y_q` was 0.
- `hi_count` output CNT_W: number of sampled cycles in which every bit of `y` was 1; saturating.

## Operation
- `y = a & b`, bitwise.
  - Independent of `clk`, `rst_n`, and `clr`.
  - Valid whenever the inputs are stable, including during reset.
- On each rising `clk` edge with `rst_n`=1:
  - `y_q <= y`.
  - `y_rise <= y & ~y_q`, using the pre-edge `y_q`.
  - `hi_count`:
    - if `clr`=1, `hi_count <= 0`;
    - else if `&y`=1 and `hi_count` is not all-ones, `hi_count <= hi_count + 1`;
    - otherwise hold.
- Saturation: `hi_count` stops at 2^CNT_W−1 and does not wrap.
- Priority: `rst_n`=0 over `clr` over increment.
- X/Z on `a` or `b` propagates per standard AND semantics. A 0 on either input forces the corresponding `y` bit to 0.
- No state machine; the stored state is `y_q`, `y_rise`, and `hi_count`.

## Timing
- `y`: zero-cycle latency, combinational path only, no clock dependency.
- `y_q`: 1-cycle latency from `y`.
- `y_rise`: asserted for exactly one cycle, the cycle after `y` first samples 1 following a sampled 0.
  - A steady 1 yields one pulse only.
- `hi_count`: reflects a sampled all-ones `y` one cycle later.
- Reset, on a rising edge with `rst_n`=0: `y_q`=0, `y_rise`=0, `hi_count`=0.
  - First edge after release: `y_rise` may assert if `y`=1, because `y_q` starts at 0.
- Reset asserted mid-count clears the count on that edge. `y` continues to follow the inputs.
- `clr` asserted together with an all-ones `y`: the count becomes 0, not 1.

## Structure
- Package `and_gate_pkg` holds:
  - default constants `AND_WIDTH_DEF`=1 and `AND_CNT_W_DEF`=16;
  - the typedef `and_cnt_t` (logic [CNT_W-1:0]).
- One natural sub-module, `and_sat_counter`: parameterized CNT_W, with inputs `clk`, `rst_n`, `clr`, `inc` and output `count`, saturating.
- The top contains the combinational AND, the `y_q`/`y_rise` registers, and the counter instance with `inc = &y`.

## Test plan
- Truth table, WIDTH=1, 5 time units per step, no clock required:
  - (a,b) = 00 → y=0;
  - 01 → y=0;
  - 10 → y=0;
  - 11 → y=1.
  - `y` settles in zero time after each change.
- Reset: hold `rst_n`=0 for 2 edges with a=b=1 → `y`=1, `y_q`=0, `y_rise`=0, `hi_count`=0.
  - Release → `y_q`=1 and `y_rise`=1 after the first edge.
  - `y_rise`=0 after the second edge.
- Counting: a=b=1 for 5 edges, then a=0 for 3 edges → `hi_count`=5 and holds at 5.
- Saturation: CNT_W=3, a=b=1 for 10 edges → `hi_count` reaches 7 and stays at 7.
- Clear priority: `hi_count`=4, assert `clr` with a=b=1 for one edge → `hi_count`=0; next edge with `clr`=0 → 1.
- WIDTH=4: a=4'b1100, b=4'b1010 → y=4'b1000, no `hi_count` increment.
  - Next a=b=4'hF → y=4'hF.
  - After the edge: `y_rise`=4'b0111, `hi_count`+1.
